// File: rtl/register_file.sv
// Two-read, one-write register file with x0 hardwired to zero, write-first bypass
// and a debug count of committed writes.
module register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [$clog2(NUM_REGS)-1:0]     rs1_addr,
  input  logic [$clog2(NUM_REGS)-1:0]     rs2_addr,
  input  logic [$clog2(NUM_REGS)-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0]           rd_data,
  input  logic                            we,
  output logic [DATA_WIDTH-1:0]           rs1_data,
  output logic [DATA_WIDTH-1:0]           rs2_data,
  output logic [7:0]                      write_count
);

  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  armed;
  logic                  commit;

  // armed stays low through the first edge after reset release, so an edge that
  // coincides with deassertion can never commit a write.
  assign commit = rst_n && armed && we && (rd_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed       <= 1'b0;
      write_count <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      armed <= 1'b1;
      if (commit) begin
        regs[rd_addr] <= rd_data;
        write_count   <= write_count + 8'd1;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  hit
  );
    if (!rst_n || addr == '0) begin
      return '0;
    end else if (hit) begin
      return rd_data;
    end else begin
      return stored;
    end
  endfunction

  // Write-first bypass: a same-cycle write to the read address wins over storage.
  assign rs1_data = read_port(rs1_addr, regs[rs1_addr], commit && (rd_addr == rs1_addr));
  assign rs2_data = read_port(rs2_addr, regs[rs2_addr], commit && (rd_addr == rs2_addr));

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: an array-based reference model checked every cycle,
// plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_register_file;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_addr = '0;
  logic [4:0] rs2_addr = '0;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_data = '0;
  logic       we = 1'b0;
  logic [7:0] rs1_data;
  logic [7:0] rs2_data;
  logic [7:0] write_count;

  int tests = 0;
  int fails = 0;

  register_file #(.DATA_WIDTH(8), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .we(we),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .write_count(write_count)
  );

  always #10 clk = ~clk;

  // Reference model: architectural contents, commit count, edges since reset release.
  logic [7:0] mdl [32];
  logic [7:0] mcount;
  int         edges_since_rst;

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
    mcount = 8'h00;
    edges_since_rst = 0;
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
    mcount = 8'h00;
    edges_since_rst = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (edges_since_rst >= 1 && we === 1'b1 && rd_addr != 5'd0) begin
        mdl[rd_addr] = rd_data;
        mcount = mcount + 8'd1;
      end
      edges_since_rst++;
    end
  end

  function automatic logic [7:0] expect_read(input logic [4:0] a);
    if (rst_n !== 1'b1 || a == 5'd0) return 8'h00;
    if (we === 1'b1 && rd_addr == a && edges_since_rst >= 1) return rd_data;
    return mdl[a];
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, mid-low-phase, compare the DUT against the model.
  always begin
    @(negedge clk);
    #2;
    chk("model_rs1", rs1_data, expect_read(rs1_addr));
    chk("model_rs2", rs2_data, expect_read(rs2_addr));
    chk("model_count", write_count, mcount);
  end

  task automatic drive(input logic w, input logic [4:0] rd, input logic [7:0] d,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    we = w; rd_addr = rd; rd_data = d; rs1_addr = a1; rs2_addr = a2;
    #2;
  endtask

  initial begin
    repeat (2) @(negedge clk);

    // Writes and bypass are suppressed while in reset.
    drive(1'b1, 5'd5, 8'h77, 5'd5, 5'd5);
    chk("rst_bypass_rs1", rs1_data, 8'h00);
    chk("rst_bypass_rs2", rs2_data, 8'h00);

    // Release reset with a write pending: the first edge after release must not commit.
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("release_no_bypass", rs1_data, 8'h00);
    drive(1'b0, 5'd0, 8'h00, 5'd5, 5'd5);
    chk("first_edge_no_commit", rs1_data, 8'h00);
    chk("first_edge_count", write_count, 8'h00);

    // All addresses read zero on both ports after reset.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 8'h00, 5'(a), 5'(31 - a));
      chk("reset_rs1", rs1_data, 8'h00);
      chk("reset_rs2", rs2_data, 8'h00);
    end
    chk("reset_count", write_count, 8'h00);

    // Basic write then read on both ports.
    drive(1'b1, 5'd3, 8'hA5, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 8'h00, 5'd3, 5'd3);
    chk("x3_rs1", rs1_data, 8'hA5);
    chk("x3_rs2", rs2_data, 8'hA5);
    chk("x3_count", write_count, 8'd1);

    // Writes to x0 are discarded and never bypassed.
    drive(1'b1, 5'd0, 8'hFF, 5'd0, 5'd0);
    chk("x0_same_rs1", rs1_data, 8'h00);
    chk("x0_same_rs2", rs2_data, 8'h00);
    drive(1'b0, 5'd0, 8'h00, 5'd0, 5'd0);
    chk("x0_next_rs1", rs1_data, 8'h00);
    chk("x0_count", write_count, 8'd1);

    // Bypass on one port while the other reads storage.
    drive(1'b1, 5'd7, 8'h11, 5'd0, 5'd0);
    drive(1'b1, 5'd8, 8'h33, 5'd0, 5'd0);
    drive(1'b1, 5'd7, 8'h22, 5'd7, 5'd8);
    chk("bypass_rs1", rs1_data, 8'h22);
    chk("bypass_rs2_storage", rs2_data, 8'h33);
    drive(1'b0, 5'd0, 8'h00, 5'd7, 5'd7);
    chk("x7_after", rs1_data, 8'h22);
    chk("x7_after_rs2", rs2_data, 8'h22);

    // Both ports bypassing the same address.
    drive(1'b1, 5'd9, 8'h44, 5'd9, 5'd9);
    chk("dual_bypass_rs1", rs1_data, 8'h44);
    chk("dual_bypass_rs2", rs2_data, 8'h44);
    drive(1'b0, 5'd0, 8'h00, 5'd9, 5'd3);
    chk("count_five", write_count, 8'd5);

    // 256 writes to x1: counter wraps through 0 and returns to its start value.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 5'd1, 8'(i) ^ 8'h3C, 5'd1, 5'd3);
      if (i == 251) chk("wrap_zero", write_count, 8'h00);
    end
    drive(1'b0, 5'd0, 8'h00, 5'd1, 5'd1);
    chk("x1_last", rs1_data, 8'hC3);
    chk("wrap_count", write_count, 8'd5);

    // Unknown write data with we low leaves state alone.
    drive(1'b0, 5'd1, 8'hxx, 5'd1, 5'd3);
    drive(1'b0, 5'd0, 8'h00, 5'd1, 5'd3);
    chk("x_data_x1", rs1_data, 8'hC3);
    chk("x_data_x3", rs2_data, 8'hA5);

    // Asynchronous reset pulse between edges clears everything.
    drive(1'b1, 5'd9, 8'h5A, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 8'h00, 5'd9, 5'd1);
    chk("x9_before_rst", rs1_data, 8'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_x9", rs1_data, 8'h00);
    chk("async_rst_x1", rs2_data, 8'h00);
    chk("async_rst_count", write_count, 8'h00);
    #2 rst_n = 1'b1;
    drive(1'b0, 5'd0, 8'h00, 5'd9, 5'd3);
    chk("post_rst_x9", rs1_data, 8'h00);
    chk("post_rst_x3", rs2_data, 8'h00);
    drive(1'b1, 5'd4, 8'h66, 5'd4, 5'd0);
    chk("post_rst_bypass", rs1_data, 8'h66);
    drive(1'b0, 5'd0, 8'h00, 5'd4, 5'd9);
    chk("post_rst_write", rs1_data, 8'h66);
    chk("post_rst_count", write_count, 8'd1);

    drive(1'b0, 5'd0, 8'h00, 5'd0, 5'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of each register and of all data ports.
REQ-002 The block SHALL have parameter NUM_REGS, default 32: number of architectural registers, a power of two, at least 2.
REQ-003 The block SHALL derive local ADDR_WIDTH = log2(NUM_REGS), 5 at defaults.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port rs1_addr, input, ADDR_WIDTH bits: read port 1 register index.
REQ-007 The block SHALL have port rs2_addr, input, ADDR_WIDTH bits: read port 2 register index.
REQ-008 The block SHALL have port rd_addr, input, ADDR_WIDTH bits: write port register index.
REQ-009 The block SHALL have port rd_data, input, DATA_WIDTH bits: write data.
REQ-010 The block SHALL have port we, input, 1 bit: write enable.
REQ-011 The block SHALL have port rs1_data, output, DATA_WIDTH bits: read data 1, feeding the operand-select muxes.
REQ-012 The block SHALL have port rs2_data, output, DATA_WIDTH bits: read data 2, feeding the operand-select muxes.
REQ-013 The block SHALL have port write_count, output, 8 bits: count of committed writes, for debug.

Function
REQ-014 Storage SHALL be NUM_REGS registers of DATA_WIDTH bits; register 0 SHALL always read 0.
REQ-015 Write: on a rising clk edge with we=1 and rd_addr!=0, rd_data SHALL be stored in reg[rd_addr]; the new value SHALL be visible from the following cycle.
REQ-016 A write with rd_addr=0 SHALL be discarded and SHALL NOT increment write_count.
REQ-017 Reads SHALL be combinational (zero latency): rsN_data = reg[rsN_addr].
REQ-018 Bypass: if we=1, rd_addr!=0 and rd_addr==rsN_addr in the same cycle, rsN_data SHALL equal rd_data (write-first), independently for each port.
REQ-019 rsN_addr=0 SHALL return 0 even when we=1 and rd_addr=0 with nonzero rd_data.
REQ-020 Both read ports SHALL be able to read the same address simultaneously with identical results, including the bypass case.
REQ-021 write_count SHALL increment by 1 on each committed write (REQ-015), wrapping from 255 to 0.
REQ-022 X on rd_data SHALL NOT affect state when we=0.

Reset
REQ-023 While rst_n=0, all registers and write_count SHALL be 0 immediately, with no clock required.
REQ-024 While rst_n=0, writes SHALL be ignored and both read ports SHALL return 0, bypass included.
REQ-025 A rising clk edge coinciding with rst_n deassertion SHALL NOT commit a write; the first write SHALL commit on the next edge.
REQ-026 Reset asserted mid-sequence SHALL clear all prior writes; no register SHALL retain its pre-reset value.

Verification
REQ-027 Reset, then read all 32 addresses on both ports -> all 0, write_count=0.
REQ-028 Write 0xA5 to x3, next cycle rs1_addr=3, rs2_addr=3 -> both 0xA5, write_count=1.
REQ-029 Write 0xFF to x0, read x0 on both ports in the same cycle and the next -> 0x00 throughout, write_count unchanged.
REQ-030 x7 holds 0x11; in one cycle we=1, rd_addr=7, rd_data=0x22, rs1_addr=7, rs2_addr=8 -> rs1_data=0x22 same cycle, rs2_data=reg[8]; next cycle x7 reads 0x22.
REQ-031 256 writes to x1 -> write_count wraps to 0; x1 holds the last value written.
REQ-032 Write 0x5A to x9, pulse rst_n low between clock edges -> rs1_data (x9) drops to 0 asynchronously and stays 0 after release.
